// File: rtl/washer_actuator_plant.sv
// washer_actuator_plant: washer actuator plant model (water level, drum ramp, sticky fault); optional leak via PLANT_LEAK_EN
module washer_actuator_plant #(
  parameter int LW          = 8,
  parameter int LEVEL_MAX   = 200,
  parameter int FULL_THRESH = 160,
  parameter int FILL_RATE   = 4,
  parameter int DRAIN_RATE  = 8,
  parameter int DW          = 8,
  parameter int SLOW_MAX    = 20,
  parameter int SPIN_MAX    = 100,
  parameter int RAMP_DIV    = 2,
  parameter int OVF_CYC     = 16,
  parameter int LEAK_PERIOD = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          water,
  input  logic          pump,
  input  logic          motor,
  input  logic          speed,
  input  logic          agitator,
  input  logic          door,
  input  logic          fault_clr,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] drum,
  output logic          at_speed,
  output logic          door_locked,
  output logic          fault,
  output logic [2:0]    fault_code
);
  localparam int PW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam int OW = $clog2(OVF_CYC + 1);
  logic [LW-1:0] r_level, w_level_nxt;
  logic [LW:0]   w_sum, w_dec;
  logic [DW-1:0] r_drum, r_tgt, w_tgt, w_drum_nxt;
  logic [PW-1:0] r_pre, w_pre;
  logic [OW-1:0] r_ovf, w_ovf;
  logic [2:0]    r_code, w_code;
  logic          r_fault, w_fill, w_drain, w_step, w_leak;
`ifdef PLANT_LEAK_EN
  localparam int KW = LEAK_PERIOD > 1 ? $clog2(LEAK_PERIOD) : 1;
  logic [KW-1:0] r_leak;
  assign w_leak = !water && r_level != '0 && r_leak == KW'(LEAK_PERIOD - 1);
  // leak prescaler: counts idle-valve cycles with water in the tank, restarts on fill
  always_ff @(posedge clk) begin
    if (rst || water) r_leak <= '0;
    else if (r_level != '0) r_leak <= w_leak ? '0 : r_leak + KW'(1);
  end
`else
  assign w_leak = (LEAK_PERIOD < 0);
`endif
  // next-state for level, drum ramp, overfill timer and fault priority
  always_comb begin
    w_fill      = water & ~pump;
    w_drain     = pump & ~water;
    w_sum       = {1'b0, r_level} + (LW+1)'(FILL_RATE);
    w_dec       = (w_drain ? (LW+1)'(DRAIN_RATE) : '0) + (LW+1)'(w_leak);
    w_level_nxt = w_fill ? (w_sum >= (LW+1)'(LEVEL_MAX) ? LW'(LEVEL_MAX) : w_sum[LW-1:0])
                         : ({1'b0, r_level} < w_dec ? '0 : r_level - w_dec[LW-1:0]);
    w_tgt       = !motor ? '0 : speed ? DW'(SPIN_MAX) : DW'(SLOW_MAX);
    w_pre       = w_tgt != r_tgt ? '0 : r_pre;
    w_step      = w_pre == PW'(RAMP_DIV - 1);
    w_drum_nxt  = (!w_step || r_drum == w_tgt) ? r_drum
                : r_drum < w_tgt ? r_drum + DW'(1) : r_drum - DW'(1);
    w_ovf       = (water && r_level == LW'(LEVEL_MAX))
                  ? (r_ovf == OW'(OVF_CYC) ? r_ovf : r_ovf + OW'(1)) : '0;
    w_code      = (water && pump)                          ? 3'd1
                : (door && r_drum != '0)                   ? 3'd2
                : (agitator && r_level < LW'(FULL_THRESH)) ? 3'd3
                : (w_ovf == OW'(OVF_CYC))                  ? 3'd4 : 3'd0;
  end
  // plant state; first fault sticks until cleared, a live condition beats the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
      r_drum  <= '0;
      r_tgt   <= '0;
      r_pre   <= '0;
      r_ovf   <= '0;
      r_code  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_drum  <= w_drum_nxt;
      r_tgt   <= w_tgt;
      r_pre   <= w_step ? '0 : w_pre + PW'(1);
      r_ovf   <= w_ovf;
      if (r_code == '0 || fault_clr) begin
        r_code  <= w_code;
        r_fault <= w_code != '0;
      end
    end
  end
  assign level       = r_level;
  assign full        = r_level >= LW'(FULL_THRESH);
  assign empty       = r_level == '0;
  assign drum        = r_drum;
  assign at_speed    = motor && r_drum == w_tgt;
  assign door_locked = r_drum != '0;
  assign fault       = r_fault;
  assign fault_code  = r_code;
endmodule
